// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
// Shares one execute-stage ALU between two requesters (req0 = main issue slot,
// req1 = auxiliary unit). Round-robin arbitration, one operation in flight,
// result sampled a fixed ALU_LATENCY cycles after issue and returned with a
// single-cycle response strobe.
//
// Optional build macro: ALU_OP_CHECK_EN
//   defined   -> illegal control codes (1001-1100, 1110, 1111) skip the ALU and
//                respond immediately with rsp_err = 1 and rsp_data = 0.
//   undefined -> every code is issued unchanged and rsp_err is tied low.
module alu_op_scheduler #(
    parameter int DATA_W      = 32,
    parameter int ALU_LATENCY = 0   // 0..7; the wait counter is only 3 bits wide
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [3:0]        alu_control_signal,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_issue,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;        // requester favoured when both are valid
    logic              id_q, id_d;          // winner of the op in flight
    logic              err_q, err_d;        // op in flight carries an illegal code
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [1:0]        req_valid;
    logic [1:0]        grant;
    logic [3:0]        req_op [2];
    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];
    logic              sel_id;
    logic [3:0]        sel_op;
    logic              handshake;
    logic              illegal_op;

    assign req_valid = {req1_valid, req0_valid};
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    // A requester wins if it is the only one asking, or if the pointer names it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (ptr_q == 1'(gi)));
        end
    endgenerate

    assign sel_id    = grant[1];
    assign sel_op    = req_op[sel_id];
    // No acceptance while reset is held, so nothing is latched into a state being cleared.
    assign handshake = (state_q == S_IDLE) && (|grant) && !reset;

`ifdef ALU_OP_CHECK_EN
    assign illegal_op = sel_op inside {[4'd9:4'd12], 4'd14, 4'd15};
`else
    assign illegal_op = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE, illegal ops jump straight to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = illegal_op ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = (LAT == 3'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers: latched request, wait counter, captured result, pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= 3'd0;
        end else begin
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            err_q    <= err_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Datapath next-state: the result is sampled on the edge that ends cycle ISSUE+ALU_LATENCY.
    always_comb begin
        ptr_d    = ptr_q;
        id_d     = id_q;
        err_d    = err_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    id_d     = sel_id;
                    op_d     = sel_op;
                    a_d      = req_a[sel_id];
                    b_d      = req_b[sel_id];
                    err_d    = illegal_op;
                    // Cleared so an illegal op (which never reaches the ALU) responds with 0.
                    result_d = '0;
                end
            end
            S_ISSUE: begin
                cnt_d = LAT;
                if (LAT == 3'd0) begin
                    result_d = alu_result;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    result_d = alu_result;
                end
            end
            S_RESP: begin
                ptr_d = ~id_q;
            end
            default: begin
            end
        endcase
    end

    // Outputs: ready only in IDLE, operands held from ISSUE through the capture cycle, strobe in RESP.
    always_comb begin
        req0_ready         = 1'b0;
        req1_ready         = 1'b0;
        alu_issue          = 1'b0;
        alu_control_signal = 4'd0;
        alu_a              = '0;
        alu_b              = '0;
        rsp_valid          = 1'b0;
        rsp_id             = 1'b0;
        rsp_data           = '0;
        rsp_err            = 1'b0;
        case (state_q)
            S_IDLE: begin
                req0_ready = grant[0] & ~reset;
                req1_ready = grant[1] & ~reset;
            end
            S_ISSUE: begin
                alu_issue          = 1'b1;
                alu_control_signal = op_q;
                alu_a              = a_q;
                alu_b              = b_q;
            end
            S_WAIT: begin
                alu_control_signal = op_q;
                alu_a              = a_q;
                alu_b              = b_q;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_data  = result_q;
`ifdef ALU_OP_CHECK_EN
                rsp_err   = err_q;
`else
                rsp_err   = 1'b0;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Testbench for alu_op_scheduler: four instances with ALU_LATENCY 0, 2, 3 and 7,
// each driven by directed scenarios and by random traffic checked against a
// transaction-timeline reference model.
module tb_alu_op_scheduler;

    localparam int          DW = 32;
    localparam int          NI = 4;
    localparam logic [31:0] K  = 32'h9E3779B1;
`ifdef ALU_OP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    function automatic int lat_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    function automatic bit illegal_code(input logic [3:0] op);
        return CHK && ((op >= 4'd9 && op <= 4'd12) || op >= 4'd14);
    endfunction

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    logic mix;   // 1: ALU model adds a per-cycle term so the capture cycle is visible

    logic          v0 [NI], v1 [NI], r0 [NI], r1 [NI];
    logic [3:0]    op0 [NI], op1 [NI], ctrl [NI];
    logic [DW-1:0] a0 [NI], b0 [NI], a1 [NI], b1 [NI];
    logic [DW-1:0] aa [NI], ab [NI], ares [NI], rdata [NI];
    logic          iss [NI], rv [NI], rid [NI], rerr [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 0 : (gi == 1) ? 2 : (gi == 2) ? 3 : 7;
            assign ares[gi] = aa[gi] + ab[gi] + (mix ? K * 32'(cyc) : 32'd0);
            alu_op_scheduler #(.DATA_W(DW), .ALU_LATENCY(LAT)) u_dut (
                .clk                (clk),
                .reset              (reset),
                .req0_valid         (v0[gi]),
                .req0_ready         (r0[gi]),
                .req0_op            (op0[gi]),
                .req0_a             (a0[gi]),
                .req0_b             (b0[gi]),
                .req1_valid         (v1[gi]),
                .req1_ready         (r1[gi]),
                .req1_op            (op1[gi]),
                .req1_a             (a1[gi]),
                .req1_b             (b1[gi]),
                .alu_control_signal (ctrl[gi]),
                .alu_a              (aa[gi]),
                .alu_b              (ab[gi]),
                .alu_issue          (iss[gi]),
                .alu_result         (ares[gi]),
                .rsp_valid          (rv[gi]),
                .rsp_id             (rid[gi]),
                .rsp_data           (rdata[gi]),
                .rsp_err            (rerr[gi])
            );
        end
    endgenerate

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            v0[k] = 1'b1;
            v1[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (r0[k] !== 1'b0 || r1[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready k=%0d: got r0=%b r1=%b expected 0 0", k, r0[k], r1[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            v0[k] = 1'b0;
            v1[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (iss[k] !== 1'b0 || ctrl[k] !== 4'd0 || aa[k] !== '0 || ab[k] !== '0 ||
                rv[k] !== 1'b0 || rid[k] !== 1'b0 || rdata[k] !== '0 || rerr[k] !== 1'b0 ||
                r0[k] !== 1'b0 || r1[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs k=%0d: got iss=%b ctrl=%h a=%h b=%h rv=%b id=%b data=%h err=%b expected all 0",
                         k, iss[k], ctrl[k], aa[k], ab[k], rv[k], rid[k], rdata[k], rerr[k]);
            end
        end
        // Pointer starts at req0.
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        #1;
        checks++;
        if (r0[0] !== 1'b1 || r1[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_pointer: got r0=%b r1=%b expected 1 0", r0[0], r1[0]);
        end
        v0[0] = 1'b0;
        v1[0] = 1'b0;
    endtask

    task automatic test_single();
        mix = 1'b0;
        @(negedge clk);
        v0[0] = 1'b1; op0[0] = 4'b0010; a0[0] = 32'd5; b0[0] = 32'd3;
        #1;
        checks++;
        if (r0[0] !== 1'b1 || r1[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: got r0=%b r1=%b expected 1 0", r0[0], r1[0]);
        end
        @(negedge clk);   // T+1
        v0[0] = 1'b0;
        #1;
        checks++;
        if (iss[0] !== 1'b1 || ctrl[0] !== 4'b0010 || aa[0] !== 32'd5 || ab[0] !== 32'd3 || rv[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_issue: got iss=%b ctrl=%h a=%0d b=%0d rv=%b expected 1 2 5 3 0",
                     iss[0], ctrl[0], aa[0], ab[0], rv[0]);
        end
        @(negedge clk);   // T+2
        #1;
        checks++;
        if (rv[0] !== 1'b1 || rid[0] !== 1'b0 || rdata[0] !== 32'd8 || rerr[0] !== 1'b0 ||
            iss[0] !== 1'b0 || ctrl[0] !== 4'd0) begin
            failures++;
            $display("FAIL single_rsp: got rv=%b id=%b data=%0d err=%b iss=%b ctrl=%h expected 1 0 8 0 0 0",
                     rv[0], rid[0], rdata[0], rerr[0], iss[0], ctrl[0]);
        end
        $display("txn single id=0 op=2 data=%0d", rdata[0]);
        v0[0] = 1'b1;
        #1;
        checks++;
        if (r0[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_ready: got %b expected 0", r0[0]);
        end
        @(negedge clk);   // T+3
        #1;
        checks++;
        if (r0[0] !== 1'b1 || rv[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_next_ready: got r0=%b rv=%b expected 1 0", r0[0], rv[0]);
        end
        v0[0] = 1'b0;
        mix = 1'b1;
    endtask

    task automatic test_contention();
        int            due_q [$];
        bit            eid_q [$];
        logic [31:0]   ed_q  [$];
        int            nhs = 0, nrsp = 0, last_hs = 0, c;
        bit            got;
        logic [31:0]   la, lb;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            v0[1] = (i < 21); v1[1] = (i < 21);
            op0[1] = 4'($urandom_range(0, 8)); op1[1] = 4'($urandom_range(0, 8));
            a0[1] = $urandom; b0[1] = $urandom; a1[1] = $urandom; b1[1] = $urandom;
            #1;
            c = cyc;
            if (due_q.size() > 0 && due_q[0] == c) begin
                checks++;
                if (rv[1] !== 1'b1 || rid[1] !== eid_q[0] || rdata[1] !== ed_q[0]) begin
                    failures++;
                    $display("FAIL contention_rsp cyc=%0d: got rv=%b id=%b data=%h expected 1 %0d %h",
                             c, rv[1], rid[1], rdata[1], eid_q[0], ed_q[0]);
                end
                $display("txn contention id=%0d data=%h", eid_q[0], ed_q[0]);
                void'(due_q.pop_front()); void'(eid_q.pop_front()); void'(ed_q.pop_front());
                nrsp++;
            end else begin
                checks++;
                if (rv[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL contention_idle_rsp cyc=%0d: got rv=%b expected 0", c, rv[1]);
                end
            end
            if ((r0[1] && v0[1]) || (r1[1] && v1[1])) begin
                got = r1[1];
                checks++;
                if (got !== 1'(nhs % 2) || (r0[1] && r1[1])) begin
                    failures++;
                    $display("FAIL contention_order hs=%0d: got r0=%b r1=%b expected winner %0d", nhs, r0[1], r1[1], nhs % 2);
                end
                if (nhs > 0) begin
                    checks++;
                    if (c - last_hs != 5) begin
                        failures++;
                        $display("FAIL contention_spacing hs=%0d: got %0d cycles expected 5", nhs, c - last_hs);
                    end
                end
                la = got ? a1[1] : a0[1];
                lb = got ? b1[1] : b0[1];
                due_q.push_back(c + 4);
                eid_q.push_back(got);
                ed_q.push_back(la + lb + K * 32'(c + 3));
                last_hs = c;
                nhs++;
            end
        end
        checks++;
        if (nhs != 5 || nrsp != 5) begin
            failures++;
            $display("FAIL contention_count: got hs=%0d rsp=%0d expected 5 5", nhs, nrsp);
        end
    endtask

    task automatic test_illegal_op();
        int          t;
        bit          saw_iss = 1'b0;
        bit          exp_rv;
        logic [31:0] la, lb;
        @(negedge clk);
        v1[2] = 1'b1; op1[2] = 4'b1111; a1[2] = $urandom; b1[2] = $urandom;
        la = a1[2]; lb = b1[2];
        #1;
        t = cyc;
        checks++;
        if (r1[2] !== 1'b1) begin
            failures++;
            $display("FAIL illegal_ready: got %b expected 1", r1[2]);
        end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            v1[2] = 1'b0;
            #1;
            if (iss[2] === 1'b1) saw_iss = 1'b1;
`ifdef ALU_OP_CHECK_EN
            exp_rv = (i == 1);
            checks++;
            if (rv[2] !== exp_rv || (exp_rv && (rid[2] !== 1'b1 || rerr[2] !== 1'b1 || rdata[2] !== '0))) begin
                failures++;
                $display("FAIL illegal_rsp cyc=%0d: got rv=%b id=%b err=%b data=%h expected rv=%b id=1 err=1 data=0",
                         cyc, rv[2], rid[2], rerr[2], rdata[2], exp_rv);
            end
`else
            exp_rv = (i == 5);
            if (i == 1) begin
                checks++;
                if (iss[2] !== 1'b1 || ctrl[2] !== 4'b1111) begin
                    failures++;
                    $display("FAIL illegal_issue: got iss=%b ctrl=%h expected 1 f", iss[2], ctrl[2]);
                end
            end
            checks++;
            if (rv[2] !== exp_rv ||
                (exp_rv && (rid[2] !== 1'b1 || rerr[2] !== 1'b0 || rdata[2] !== la + lb + K * 32'(t + 4)))) begin
                failures++;
                $display("FAIL illegal_rsp cyc=%0d: got rv=%b id=%b err=%b data=%h expected rv=%b id=1 err=0 data=%h",
                         cyc, rv[2], rid[2], rerr[2], rdata[2], exp_rv, la + lb + K * 32'(t + 4));
            end
`endif
            if (exp_rv) $display("txn illegal id=1 op=f err=%b data=%h", rerr[2], rdata[2]);
        end
        checks++;
        if (saw_iss !== !CHK) begin
            failures++;
            $display("FAIL illegal_issue_seen: got %b expected %b", saw_iss, !CHK);
        end
    endtask

    task automatic test_reset_mid_op();
        // Complete one req0 op first so the pointer moves to req1.
        @(negedge clk);
        v0[2] = 1'b1; op0[2] = 4'd3; a0[2] = $urandom; b0[2] = $urandom;
        @(negedge clk);
        v0[2] = 1'b0;
        repeat (6) @(negedge clk);
        // Second op, interrupted during WAIT.
        v0[2] = 1'b1;
        #1;
        checks++;
        if (r0[2] !== 1'b1) begin
            failures++;
            $display("FAIL midop_ready: got %b expected 1", r0[2]);
        end
        @(negedge clk);   // ISSUE
        v0[2] = 1'b0;
        @(negedge clk);   // WAIT
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (iss[2] !== 1'b0 || ctrl[2] !== 4'd0 || aa[2] !== '0 || ab[2] !== '0 || rv[2] !== 1'b0 ||
            rid[2] !== 1'b0 || rdata[2] !== '0 || rerr[2] !== 1'b0 || r0[2] !== 1'b0 || r1[2] !== 1'b0) begin
            failures++;
            $display("FAIL midop_outputs: got iss=%b ctrl=%h a=%h b=%h rv=%b data=%h expected all 0",
                     iss[2], ctrl[2], aa[2], ab[2], rv[2], rdata[2]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rv[2] !== 1'b0 || iss[2] !== 1'b0) begin
                failures++;
                $display("FAIL midop_no_rsp cyc=%0d: got rv=%b iss=%b expected 0 0", cyc, rv[2], iss[2]);
            end
        end
        v0[2] = 1'b1;
        v1[2] = 1'b1;
        #1;
        checks++;
        if (r0[2] !== 1'b1 || r1[2] !== 1'b0) begin
            failures++;
            $display("FAIL midop_pointer: got r0=%b r1=%b expected 1 0", r0[2], r1[2]);
        end
        v0[2] = 1'b0;
        v1[2] = 1'b0;
    endtask

    // Random traffic against a timeline model: each accepted op occupies the ALU
    // from handshake+1 to handshake+1+L and responds at handshake+2+L (or +1 if illegal).
    task automatic test_latency_sweep(input int k, input int ncyc);
        int          lat = lat_of(k);
        int          next_free = 0, hs_c = 0, rsp_c = 0, c;
        bit          ptr = 1'b0, have = 1'b0, t_id = 1'b0, t_ill = 1'b0;
        logic [3:0]  t_op = 4'd0;
        logic [31:0] t_a = '0, t_b = '0;
        bit          free, e_r0, e_r1, e_iss, e_hold, e_rsp;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b, e_data;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            v0[k] = ($urandom_range(0, 2) != 0);
            v1[k] = ($urandom_range(0, 2) != 0);
            op0[k] = 4'($urandom_range(0, 15)); op1[k] = 4'($urandom_range(0, 15));
            a0[k] = $urandom; b0[k] = $urandom; a1[k] = $urandom; b1[k] = $urandom;
            #1;
            c      = cyc;
            free   = (c >= next_free);
            e_r0   = free && v0[k] && (!v1[k] || !ptr);
            e_r1   = free && v1[k] && (!v0[k] || ptr);
            e_iss  = have && !t_ill && (c == hs_c + 1);
            e_hold = have && !t_ill && (c >= hs_c + 1) && (c <= hs_c + 1 + lat);
            e_rsp  = have && (c == rsp_c);
            e_op   = e_hold ? t_op : 4'd0;
            e_a    = e_hold ? t_a : '0;
            e_b    = e_hold ? t_b : '0;
            e_data = (e_rsp && !t_ill) ? (t_a + t_b + K * 32'(hs_c + 1 + lat)) : '0;
            checks++;
            if (r0[k] !== e_r0) begin
                failures++;
                $display("FAIL sweep_ready0 k=%0d cyc=%0d: got %b expected %b", k, c, r0[k], e_r0);
            end
            checks++;
            if (r1[k] !== e_r1) begin
                failures++;
                $display("FAIL sweep_ready1 k=%0d cyc=%0d: got %b expected %b", k, c, r1[k], e_r1);
            end
            checks++;
            if (iss[k] !== e_iss) begin
                failures++;
                $display("FAIL sweep_issue k=%0d cyc=%0d: got %b expected %b", k, c, iss[k], e_iss);
            end
            checks++;
            if (ctrl[k] !== e_op || aa[k] !== e_a || ab[k] !== e_b) begin
                failures++;
                $display("FAIL sweep_operands k=%0d cyc=%0d: got ctrl=%h a=%h b=%h expected ctrl=%h a=%h b=%h",
                         k, c, ctrl[k], aa[k], ab[k], e_op, e_a, e_b);
            end
            checks++;
            if (rv[k] !== e_rsp) begin
                failures++;
                $display("FAIL sweep_rsp_valid k=%0d cyc=%0d: got %b expected %b", k, c, rv[k], e_rsp);
            end
            checks++;
            if (rid[k] !== (e_rsp && t_id) || rdata[k] !== e_data || rerr[k] !== (e_rsp && t_ill)) begin
                failures++;
                $display("FAIL sweep_rsp_payload k=%0d cyc=%0d: got id=%b data=%h err=%b expected id=%b data=%h err=%b",
                         k, c, rid[k], rdata[k], rerr[k], e_rsp && t_id, e_data, e_rsp && t_ill);
            end
            if (e_rsp) $display("txn sweep k=%0d lat=%0d id=%0d op=%h data=%h err=%0d", k, lat, t_id, t_op, e_data, t_ill);
            if (e_r0 || e_r1) begin
                have  = 1'b1;
                hs_c  = c;
                t_id  = e_r1;
                t_op  = e_r1 ? op1[k] : op0[k];
                t_a   = e_r1 ? a1[k] : a0[k];
                t_b   = e_r1 ? b1[k] : b0[k];
                t_ill = illegal_code(t_op);
                rsp_c = t_ill ? c + 1 : c + 2 + lat;
                next_free = rsp_c + 1;
                ptr   = ~e_r1;
            end
        end
        v0[k] = 1'b0;
        v1[k] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mix   = 1'b1;
        for (int k = 0; k < NI; k++) begin
            v0[k] = 1'b0; v1[k] = 1'b0;
            op0[k] = 4'd0; op1[k] = 4'd0;
            a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_illegal_op();
        test_reset_mid_op();
        for (int k = 0; k < NI; k++) begin
            test_latency_sweep(k, 250);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares the single execute-stage ALU between two requesters: req0 is the main pipeline issue slot, req1 is an auxiliary unit such as address generation or multi-cycle helper.
- Arbitrates round-robin and holds one operation in flight at a time.
- Drives the 4-bit ALU control code that feeds the ALU op decoder, plus the operands.
- Samples the ALU result after a fixed latency and returns it to the winning requester with a one-cycle response strobe.

Parameters:
- DATA_W, 32, operand/result width.
- ALU_LATENCY, 0, cycles from the ALU issue cycle to the result-valid cycle (legal 0..7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  4  ALU control code.
- req0_a  in  DATA_W  operand A.
- req0_b  in  DATA_W  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as req0, for requester 1.
- alu_control_signal  out  4  code to the ALU op decoder.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_issue  out  1  ALU op launched this cycle.
- alu_result  in  DATA_W  ALU output.
- rsp_valid  out  1  response strobe, one cycle.
- rsp_id  out  1  0 = req0, 1 = req1.
- rsp_data  out  DATA_W  captured result.
- rsp_err  out  1  illegal opcode, only with the optional feature.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, priority pointer = req0.
  - All outputs 0: alu_control_signal = 4'b0000, alu_a/alu_b = 0, alu_issue = 0, rsp_* = 0, both ready = 0.
- Reset mid-operation: the in-flight op is discarded with no response; the next cycle is IDLE.
- State IDLE:
  - Grant = the requester with valid. If both are valid, grant the one named by the pointer.
  - reqN_ready is combinational: 1 only for the granted requester, only in IDLE.
  - On handshake (valid & ready): latch op, a, b and id; go to ISSUE.
  - No valid: stay in IDLE.
- State ISSUE, one cycle:
  - alu_issue = 1; drive alu_control_signal/alu_a/alu_b from the latched values.
  - Load the wait counter with ALU_LATENCY.
  - If ALU_LATENCY = 0, capture alu_result at the end of this cycle and go to RESP. Otherwise go to WAIT.
- State WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture alu_result at the clock edge and go to RESP.
  - Result is therefore captured exactly ALU_LATENCY cycles after the ISSUE cycle.
- Operand hold: alu_control_signal, alu_a and alu_b hold the latched values from ISSUE through the capture cycle. They return to 0 in RESP and IDLE.
- State RESP, one cycle:
  - rsp_valid = 1, rsp_id = latched id, rsp_data = captured result.
  - Pointer is set to the requester that did not win.
  - Next state is IDLE.
  - There is no response backpressure; requesters must sink the strobe.
- Timing: handshake in cycle T → alu_issue at T+1 → rsp_valid at T+2+ALU_LATENCY → next handshake earliest at T+3+ALU_LATENCY.
- Arbitration fairness: a requester holding valid is served within two operations. A single active requester is served every slot regardless of the pointer.
- Request changes while busy: both ready = 0 outside IDLE. Changes on req inputs while busy have no effect.
- Widths: no arithmetic on data; data passes through unchanged. The counter is 3 bits.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined:
  - Legal codes are 0000–1000 and 1101.
  - An accepted illegal code (1001–1100, 1110, 1111) skips ISSUE/WAIT: IDLE → RESP on the next cycle.
  - In that response rsp_err = 1, rsp_data = 0 and alu_issue is never asserted.
  - The pointer still toggles.
- Undefined:
  - Any code is issued unchanged.
  - rsp_err is tied 0.

Test Plan:
- Reset mid-op: ALU_LATENCY=3, reset asserted during WAIT → no rsp_valid; all outputs 0 next cycle; state IDLE; pointer = req0.
- Single request, ALU_LATENCY=0: req0 op=0010, a=5, b=3, ALU model returns a+b → handshake at T, alu_issue at T+1 with alu_control_signal=0010, rsp_valid at T+2, rsp_id=0, rsp_data=8.
- Contention: req0 and req1 both held valid, ALU_LATENCY=2 → grants alternate req0, req1, req0, req1; each rsp at handshake+4; the next handshake occurs 5 cycles after the previous one.
- Latency sweep: ALU_LATENCY=7, ALU model changes alu_result every cycle → rsp_data equals the alu_result value present exactly 7 cycles after the ISSUE cycle.
- Illegal op with ALU_OP_CHECK_EN, req1 op=1111 → alu_issue stays 0; rsp_valid at T+1 with rsp_id=1, rsp_err=1, rsp_data=0. Without the macro: issued normally, rsp_err=0.
